// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states, NOP encoding and
// instruction field bit positions.
package riscv_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ERROR} fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam int OP_LSB   = 0;
  localparam int RD_LSB   = 7;
  localparam int F3_LSB   = 12;
  localparam int RS1_LSB  = 15;
  localparam int RS2_LSB  = 20;
  localparam int F7B5_BIT = 30;

endpackage

// File: rtl/ifetch_unit.sv
// Multi-cycle instruction fetch: req/ack read of instruction memory into the
// instruction register, with controller stall and a sticky timeout error.
module ifetch_unit
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IRWrite,
  input  logic [XLEN-1:0] PC,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] OldPC,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            stall,
  output logic            fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  fetch_state_t  state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  // Last permitted WAIT cycle with no ack; an ack on that cycle still wins.
  assign timed_out = (wait_cnt == LAST_CNT) && !mem_ack;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = IRWrite;
        if (IRWrite) state_nxt = WAIT;
      end
      WAIT: begin
        stall = !mem_ack;
        if (mem_ack)        state_nxt = IDLE;
        else if (timed_out) state_nxt = ERROR;
      end
      ERROR: stall = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      Instr     <= XLEN'(NOP_INSTR);
      OldPC     <= '0;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IRWrite) begin
            mem_addr <= PC;
            mem_req  <= 1'b1;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            Instr   <= mem_rdata;
            OldPC   <= mem_addr;
            mem_req <= 1'b0;
          end else if (timed_out) begin
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERROR: begin
          mem_req   <= 1'b0;
          fetch_err <= 1'b1;
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

  assign op       = Instr[OP_LSB +: 7];
  assign funct3   = Instr[F3_LSB +: 3];
  assign funct7b5 = Instr[F7B5_BIT];
  assign rs1      = Instr[RS1_LSB +: 5];
  assign rs2      = Instr[RS2_LSB +: 5];
  assign rd       = Instr[RD_LSB +: 5];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: two instances (TIMEOUT=4 and 16) on shared inputs,
// directed scenarios then random traffic against a transaction-level model.
module tb_ifetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, IRWrite, mem_ack;
  logic [31:0] PC, mem_rdata;

  typedef struct packed {
    logic        req;
    logic [31:0] addr, instr, oldpc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rs1, rs2, rd;
    logic        stall, err;
  } obs_t;

  typedef struct {
    bit          busy, err, req;
    int          waited;
    logic [31:0] addr, instr, oldpc;
  } mdl_t;

  logic        a_req, a_f7b5, a_stall, a_err, b_req, b_f7b5, b_stall, b_err;
  logic [31:0] a_addr, a_instr, a_oldpc, b_addr, b_instr, b_oldpc;
  logic [6:0]  a_op, b_op;
  logic [2:0]  a_f3, b_f3;
  logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
  obs_t        a_o, b_o;

  assign a_o = {a_req, a_addr, a_instr, a_oldpc, a_op, a_f3, a_f7b5, a_rs1, a_rs2, a_rd, a_stall, a_err};
  assign b_o = {b_req, b_addr, b_instr, b_oldpc, b_op, b_f3, b_f7b5, b_rs1, b_rs2, b_rd, b_stall, b_err};

  ifetch_unit #(.XLEN(32), .TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .IRWrite(IRWrite), .PC(PC), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_req(a_req), .mem_addr(a_addr), .Instr(a_instr),
    .OldPC(a_oldpc), .op(a_op), .funct3(a_f3), .funct7b5(a_f7b5), .rs1(a_rs1),
    .rs2(a_rs2), .rd(a_rd), .stall(a_stall), .fetch_err(a_err));

  ifetch_unit #(.XLEN(32), .TIMEOUT(16)) dut16 (
    .clk(clk), .reset(reset), .IRWrite(IRWrite), .PC(PC), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_req(b_req), .mem_addr(b_addr), .Instr(b_instr),
    .OldPC(b_oldpc), .op(b_op), .funct3(b_f3), .funct7b5(b_f7b5), .rs1(b_rs1),
    .rs2(b_rs2), .rd(b_rd), .stall(b_stall), .fetch_err(b_err));

  int   n_chk = 0, n_fail = 0;
  mdl_t ma, mb;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.busy = 0; m.err = 0; m.req = 0; m.waited = 0;
    m.addr = '0; m.instr = NOP_INSTR; m.oldpc = '0;
    return m;
  endfunction

  // One clock edge of the fetch transaction, in terms of an outstanding read.
  function automatic mdl_t mdl_next(mdl_t m, int to, bit rst, bit ir,
                                    logic [31:0] pc, bit ack, logic [31:0] rdata);
    mdl_t n = m;
    if (!rst) return mdl_reset();
    if (m.err) return n;
    if (!m.busy) begin
      if (ir) begin n.busy = 1; n.req = 1; n.addr = pc; n.waited = 0; end
    end else if (ack) begin
      n.instr = rdata; n.oldpc = m.addr; n.req = 0; n.busy = 0;
    end else begin
      n.waited = m.waited + 1;
      if (n.waited == to) begin n.err = 1; n.busy = 0; n.req = 0; end
    end
    return n;
  endfunction

  task automatic chk_dut(string p, mdl_t m, obs_t o, bit ir, bit ack);
    bit exp_stall = m.err || (!m.busy && ir) || (m.busy && !ack);
    chk({p, ".mem_req"},  o.req,   m.req);
    chk({p, ".mem_addr"}, o.addr,  m.addr);
    chk({p, ".Instr"},    o.instr, m.instr);
    chk({p, ".OldPC"},    o.oldpc, m.oldpc);
    chk({p, ".op"},       o.op,    m.instr[6:0]);
    chk({p, ".funct3"},   o.f3,    m.instr[14:12]);
    chk({p, ".funct7b5"}, o.f7b5,  m.instr[30]);
    chk({p, ".rs1"},      o.rs1,   m.instr[19:15]);
    chk({p, ".rs2"},      o.rs2,   m.instr[24:20]);
    chk({p, ".rd"},       o.rd,    m.instr[11:7]);
    chk({p, ".stall"},    o.stall, exp_stall);
    chk({p, ".fetch_err"}, o.err,  m.err);
  endtask

  // Called 1 time unit after a rising edge; samples mid-cycle, returns after next edge.
  task automatic step(bit rst, bit ir, logic [31:0] pc, bit ack, logic [31:0] rdata);
    reset = rst; IRWrite = ir; PC = pc; mem_ack = ack; mem_rdata = rdata;
    #3;
    chk_dut("t4", ma, a_o, ir, ack);
    chk_dut("t16", mb, b_o, ir, ack);
    ma = mdl_next(ma, 4, rst, ir, pc, ack, rdata);
    mb = mdl_next(mb, 16, rst, ir, pc, ack, rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 0; IRWrite = 1; PC = '0; mem_ack = 0; mem_rdata = '0;
    @(posedge clk); #1;
    ma = mdl_reset(); mb = mdl_reset();

    // reset held two cycles with IRWrite asserted
    chk("rst_instr", a_instr, 32'h0000_0013);
    chk("rst_op", a_op, 32'h13);
    chk("rst_req", a_req, 0);
    chk("rst_err", a_err, 0);
    step(0, 1, 32'h0, 0, 32'h0);

    // single-wait fetch
    step(1, 1, 32'h100, 0, 32'h0);
    chk("sf_addr", a_addr, 32'h100);
    chk("sf_req", a_req, 1);
    step(1, 0, 32'h100, 1, 32'h0050_0093);
    chk("sf_instr", a_instr, 32'h0050_0093);
    chk("sf_oldpc", a_oldpc, 32'h100);
    chk("sf_rd", a_rd, 1);
    chk("sf_op", a_op, 32'h13);

    // slow memory on dut16; same traffic times out dut4 (TIMEOUT=4)
    step(1, 1, 32'h200, 0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 32'h200, 0, $urandom);
      chk("slow_addr", b_addr, 32'h200);
    end
    chk("to_err", a_err, 1);
    chk("to_req", a_req, 0);
    step(1, 0, 32'h200, 1, 32'hFE20_8EE3);
    chk("slow_instr", b_instr, 32'hFE20_8EE3);
    chk("slow_f3", b_f3, 0);
    chk("slow_op", b_op, 32'h63);
    chk("to_instr_held", a_instr, 32'h0050_0093);
    chk("to_err_sticky", a_err, 1);
    step(1, 1, 32'h240, 0, 32'h0);
    chk("to_stall_err", a_err, 1);

    // ack on the final allowed WAIT cycle
    step(0, 0, 32'h0, 0, 32'h0);
    step(1, 1, 32'h300, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h300, 0, 32'h0);
    step(1, 0, 32'h300, 1, 32'h00B5_0533);
    chk("bnd_err", a_err, 0);
    chk("bnd_instr", a_instr, 32'h00B5_0533);
    chk("bnd_req", a_req, 0);

    // reset mid-WAIT, then spurious ack in IDLE
    step(1, 1, 32'h400, 0, 32'h0);
    step(1, 0, 32'h400, 0, 32'h0);
    step(0, 0, 32'h400, 0, 32'h0);
    chk("rmw_req", a_req, 0);
    step(1, 0, 32'h0, 1, 32'hDEAD_BEEF);
    chk("spur_instr4", a_instr, 32'h0000_0013);
    chk("spur_instr16", b_instr, 32'h0000_0013);

    // random traffic with occasional resets
    repeat (3000) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0,
           $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
